// File: rtl/ir_pkg.sv
// Shared types and NEC frame field positions for the IR key controller.
package ir_pkg;

    typedef enum logic [1:0] {
        EV_NONE    = 2'd0,
        EV_PRESS   = 2'd1,
        EV_HOLD    = 2'd2,
        EV_RELEASE = 2'd3
    } ir_event_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } ir_key_state_t;

    localparam int NEC_ADDR_MSB  = 31;
    localparam int NEC_ADDR_LSB  = 24;
    localparam int NEC_NADDR_MSB = 23;
    localparam int NEC_NADDR_LSB = 16;
    localparam int NEC_CMD_MSB   = 15;
    localparam int NEC_CMD_LSB   = 8;
    localparam int NEC_NCMD_MSB  = 7;
    localparam int NEC_NCMD_LSB  = 0;

    function automatic logic nec_pair_ok(
        input logic [7:0] a,
        input logic [7:0] b
    );
        return (a ^ b) == 8'hFF;
    endfunction

endpackage

// File: rtl/ir_frame_check.sv
// One register stage: splits an NEC frame and flags checksum and filter
// status so the key FSM sees clean valid/fail strobes.
module ir_frame_check
    import ir_pkg::*;
#(
    parameter bit         FILTER_EN   = 1'b0,
    parameter logic [7:0] FILTER_ADDR = 8'h00
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_code,
    input  logic        i_strobe,
    output logic        o_valid,
    output logic        o_chk_fail,
    output logic [7:0]  o_addr,
    output logic [7:0]  o_cmd
);

    logic [7:0] w_addr;
    logic [7:0] w_naddr;
    logic [7:0] w_cmd;
    logic [7:0] w_ncmd;
    logic       w_sum_ok;
    logic       w_filt_ok;

    logic       r_valid;
    logic       r_chk_fail;
    logic [7:0] r_addr;
    logic [7:0] r_cmd;

    assign w_addr  = i_code[NEC_ADDR_MSB:NEC_ADDR_LSB];
    assign w_naddr = i_code[NEC_NADDR_MSB:NEC_NADDR_LSB];
    assign w_cmd   = i_code[NEC_CMD_MSB:NEC_CMD_LSB];
    assign w_ncmd  = i_code[NEC_NCMD_MSB:NEC_NCMD_LSB];

    assign w_sum_ok  = nec_pair_ok(w_addr, w_naddr) && nec_pair_ok(w_cmd, w_ncmd);
    assign w_filt_ok = !FILTER_EN || (w_addr == FILTER_ADDR);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid    <= 1'b0;
            r_chk_fail <= 1'b0;
            r_addr     <= 8'h00;
            r_cmd      <= 8'h00;
        end else begin
            r_valid    <= i_strobe && w_sum_ok && w_filt_ok;
            r_chk_fail <= i_strobe && !w_sum_ok;
            if (i_strobe) begin
                r_addr <= w_addr;
                r_cmd  <= w_cmd;
            end
        end
    end

    assign o_valid    = r_valid;
    assign o_chk_fail = r_chk_fail;
    assign o_addr     = r_addr;
    assign o_cmd      = r_cmd;

endmodule

// File: rtl/ir_key_controller.sv
// Turns checked NEC frames into PRESS/HOLD/RELEASE key events with a
// release timeout, repeat counting and a saturating error counter.
module ir_key_controller
    import ir_pkg::*;
#(
    parameter int         RELEASE_TIMEOUT = 12_000_000,
    parameter int         HOLD_REPEATS    = 3,
    parameter bit         FILTER_EN       = 1'b0,
    parameter logic [7:0] FILTER_ADDR     = 8'h00
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] code_in,
    input  logic        new_code_in,
    input  logic [3:0]  error_in,
    output logic [7:0]  key_out,
    output logic [7:0]  addr_out,
    output logic [1:0]  event_out,
    output logic        event_valid_out,
    output logic [1:0]  state_out,
    output logic [15:0] err_count_out
);

    localparam int TW = $clog2(RELEASE_TIMEOUT + 1);
    localparam int RW = (HOLD_REPEATS < 1) ? 1 : $clog2(HOLD_REPEATS + 1);
    localparam logic [TW-1:0] T_LOAD  = TW'(RELEASE_TIMEOUT);
    localparam logic [TW-1:0] T_ONE   = TW'(1);
    localparam logic [RW-1:0] REP_MAX = RW'(HOLD_REPEATS);
    localparam logic [RW-1:0] REP_ONE = RW'(1);

    logic          w_chk_valid;
    logic          w_chk_fail;
    logic [7:0]    w_f_addr;
    logic [7:0]    w_f_cmd;

    ir_key_state_t r_state;
    ir_key_state_t w_state_nxt;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_timer_nxt;
    logic [RW-1:0] r_rep;
    logic [RW-1:0] w_rep_nxt;
    logic [RW-1:0] w_rep_inc;
    logic          r_pend;
    logic          w_pend_nxt;
    logic [7:0]    r_lk_addr;
    logic [7:0]    r_lk_cmd;
    logic [7:0]    w_lk_addr_nxt;
    logic [7:0]    w_lk_cmd_nxt;

    logic          w_ev_fire;
    ir_event_t     w_ev;
    logic [7:0]    w_ev_key;
    logic [7:0]    w_ev_addr;

    logic [7:0]    r_key_out;
    logic [7:0]    r_addr_out;
    ir_event_t     r_event;
    logic          r_ev_valid;

    logic [15:0]   r_err;
    logic          r_err_prev;
    logic          w_dec_err;
    logic          w_frm_err;
    logic [1:0]    w_err_inc;
    logic [16:0]   w_err_sum;

    logic          w_frame;
    logic          w_same;
    logic          w_expire;

    ir_frame_check #(
        .FILTER_EN   (FILTER_EN),
        .FILTER_ADDR (FILTER_ADDR)
    ) u_check (
        .i_clk      (clk_in),
        .i_rst      (rst_in),
        .i_code     (code_in),
        .i_strobe   (new_code_in),
        .o_valid    (w_chk_valid),
        .o_chk_fail (w_chk_fail),
        .o_addr     (w_f_addr),
        .o_cmd      (w_f_cmd)
    );

    // A frame landing while a pending PRESS issues is dropped as an error.
    assign w_frame   = w_chk_valid && !r_pend;
    assign w_same    = w_frame && (w_f_addr == r_lk_addr) && (w_f_cmd == r_lk_cmd);
    assign w_expire  = (r_timer == T_ONE);
    assign w_rep_inc = (r_rep >= REP_MAX) ? REP_MAX : r_rep + REP_ONE;

    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_rep_nxt     = r_rep;
        w_pend_nxt    = r_pend;
        w_lk_addr_nxt = r_lk_addr;
        w_lk_cmd_nxt  = r_lk_cmd;
        w_ev_fire     = 1'b0;
        w_ev          = EV_NONE;
        w_ev_key      = r_lk_cmd;
        w_ev_addr     = r_lk_addr;

        if (r_state != ST_IDLE && r_timer != '0) begin
            w_timer_nxt = r_timer - T_ONE;
        end

        if (r_pend) begin
            w_ev_fire   = 1'b1;
            w_ev        = EV_PRESS;
            w_timer_nxt = T_LOAD;
            w_rep_nxt   = '0;
            w_state_nxt = ST_PRESSED;
            w_pend_nxt  = 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_frame) begin
                        w_lk_addr_nxt = w_f_addr;
                        w_lk_cmd_nxt  = w_f_cmd;
                        w_ev_fire     = 1'b1;
                        w_ev          = EV_PRESS;
                        w_ev_key      = w_f_cmd;
                        w_ev_addr     = w_f_addr;
                        w_timer_nxt   = T_LOAD;
                        w_rep_nxt     = '0;
                        w_state_nxt   = ST_PRESSED;
                    end
                end
                ST_PRESSED, ST_HELD: begin
                    if (w_same) begin
                        w_timer_nxt = T_LOAD;
                        if (r_state == ST_HELD) begin
                            w_ev_fire = 1'b1;
                            w_ev      = EV_HOLD;
                        end else begin
                            w_rep_nxt = w_rep_inc;
                            if (w_rep_inc == REP_MAX) begin
                                w_ev_fire   = 1'b1;
                                w_ev        = EV_HOLD;
                                w_state_nxt = ST_HELD;
                            end
                        end
                    end else if (w_frame) begin
                        w_ev_fire     = 1'b1;
                        w_ev          = EV_RELEASE;
                        w_pend_nxt    = 1'b1;
                        w_lk_addr_nxt = w_f_addr;
                        w_lk_cmd_nxt  = w_f_cmd;
                    end else if (w_expire) begin
                        w_ev_fire   = 1'b1;
                        w_ev        = EV_RELEASE;
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign w_dec_err = (error_in != 4'd0) && !r_err_prev;
    assign w_frm_err = w_chk_fail || (w_chk_valid && r_pend);
    assign w_err_inc = {1'b0, w_frm_err} + {1'b0, w_dec_err};
    assign w_err_sum = {1'b0, r_err} + {15'd0, w_err_inc};

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state    <= ST_IDLE;
            r_timer    <= '0;
            r_rep      <= '0;
            r_pend     <= 1'b0;
            r_lk_addr  <= 8'h00;
            r_lk_cmd   <= 8'h00;
            r_key_out  <= 8'h00;
            r_addr_out <= 8'h00;
            r_event    <= EV_NONE;
            r_ev_valid <= 1'b0;
            r_err      <= 16'h0000;
            r_err_prev <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_rep      <= w_rep_nxt;
            r_pend     <= w_pend_nxt;
            r_lk_addr  <= w_lk_addr_nxt;
            r_lk_cmd   <= w_lk_cmd_nxt;
            r_ev_valid <= w_ev_fire;
            if (w_ev_fire) begin
                r_event    <= w_ev;
                r_key_out  <= w_ev_key;
                r_addr_out <= w_ev_addr;
            end
            r_err      <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
            r_err_prev <= (error_in != 4'd0);
        end
    end

    assign key_out         = r_key_out;
    assign addr_out        = r_addr_out;
    assign event_out       = r_event;
    assign event_valid_out = r_ev_valid;
    assign state_out       = r_state;
    assign err_count_out   = r_err;

endmodule

// File: tb/tb_ir_key_controller.sv
// Bench for ir_key_controller: directed scenarios plus a randomized run
// against a deadline-based key life-cycle model.
module tb_ir_key_controller;

    localparam int T  = 1000;
    localparam int HR = 2;

    logic        clk = 1'b0;
    logic        rst_in = 1'b1;
    logic [31:0] code_in = 32'h0;
    logic        new_code_in = 1'b0;
    logic [3:0]  error_in = 4'h0;

    logic [7:0]  key_out, addr_out;
    logic [1:0]  event_out, state_out;
    logic        event_valid_out;
    logic [15:0] err_count_out;

    logic [7:0]  f_key, f_addr;
    logic [1:0]  f_event, f_state;
    logic        f_valid;
    logic [15:0] f_err;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    ir_key_controller #(
        .RELEASE_TIMEOUT (T),
        .HOLD_REPEATS    (HR),
        .FILTER_EN       (1'b0),
        .FILTER_ADDR     (8'h00)
    ) u_dut (
        .clk_in          (clk),
        .rst_in          (rst_in),
        .code_in         (code_in),
        .new_code_in     (new_code_in),
        .error_in        (error_in),
        .key_out         (key_out),
        .addr_out        (addr_out),
        .event_out       (event_out),
        .event_valid_out (event_valid_out),
        .state_out       (state_out),
        .err_count_out   (err_count_out)
    );

    ir_key_controller #(
        .RELEASE_TIMEOUT (T),
        .HOLD_REPEATS    (HR),
        .FILTER_EN       (1'b1),
        .FILTER_ADDR     (8'h00)
    ) u_flt (
        .clk_in          (clk),
        .rst_in          (rst_in),
        .code_in         (code_in),
        .new_code_in     (new_code_in),
        .error_in        (error_in),
        .key_out         (f_key),
        .addr_out        (f_addr),
        .event_out       (f_event),
        .event_valid_out (f_valid),
        .state_out       (f_state),
        .err_count_out   (f_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        new_code_in = 1'b0;
        error_in = 4'h0;
        code_in = 32'h0;
        tick();
        rst_in = 1'b0;
    endtask

    task automatic send(input logic [31:0] c);
        code_in = c;
        new_code_in = 1'b1;
        tick();
        new_code_in = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if ({key_out, addr_out, event_out, event_valid_out, state_out, err_count_out} !== 37'd0)
            $display("FAIL reset_outputs got k=%h a=%h e=%0d v=%b s=%0d err=%0d want all 0",
                     key_out, addr_out, event_out, event_valid_out, state_out, err_count_out);
        else n_pass++;
    endtask

    task automatic test_single_press();
        int k;
        do_reset();
        send(32'h00FF_A25D);
        n_total++;
        if (event_valid_out !== 1'b0)
            $display("FAIL press_early got v=%b want 0", event_valid_out);
        else n_pass++;
        tick();
        n_total++;
        if ({event_valid_out, event_out, key_out, addr_out, state_out} !== {1'b1, 2'd1, 8'hA2, 8'h00, 2'd1})
            $display("FAIL press_event got v=%b e=%0d k=%h a=%h s=%0d want 1 1 a2 00 1",
                     event_valid_out, event_out, key_out, addr_out, state_out);
        else n_pass++;
        k = 0;
        for (int i = 1; i <= T + 100; i++) begin
            tick();
            if (event_valid_out) begin
                k = i;
                break;
            end
        end
        n_total++;
        if (k !== T || event_out !== 2'd3 || key_out !== 8'hA2 || state_out !== 2'd0)
            $display("FAIL release_timeout got dt=%0d e=%0d k=%h s=%0d want %0d 3 a2 0",
                     k, event_out, key_out, state_out, T);
        else n_pass++;
    endtask

    task automatic test_errors();
        do_reset();
        send(32'hABCD_1234);
        tick();
        n_total++;
        if (event_valid_out !== 1'b0 || err_count_out !== 16'd1)
            $display("FAIL checksum got v=%b err=%0d want 0 1", event_valid_out, err_count_out);
        else n_pass++;
        error_in = 4'd4;
        tick();
        tick();
        error_in = 4'd0;
        tick();
        n_total++;
        if (err_count_out !== 16'd2 || f_err !== 16'd2)
            $display("FAIL decoder_err got err=%0d ferr=%0d want 2 2", err_count_out, f_err);
        else n_pass++;
    endtask

    task automatic test_hold();
        int k;
        bit quiet;
        do_reset();
        send(32'h00FF_A25D);
        tick();
        n_total++;
        if ({event_valid_out, event_out} !== {1'b1, 2'd1})
            $display("FAIL hold_press got v=%b e=%0d want 1 1", event_valid_out, event_out);
        else n_pass++;
        for (int r = 0; r < 3; r++) begin
            quiet = 1'b1;
            for (int i = 0; i < 498; i++) begin
                tick();
                if (event_valid_out) quiet = 1'b0;
            end
            send(32'h00FF_A25D);
            if (event_valid_out) quiet = 1'b0;
            tick();
            n_total++;
            if (r == 0) begin
                if (!quiet || event_valid_out !== 1'b0 || state_out !== 2'd1)
                    $display("FAIL repeat_quiet got quiet=%b v=%b s=%0d want 1 0 1",
                             quiet, event_valid_out, state_out);
                else n_pass++;
            end else begin
                if (!quiet || {event_valid_out, event_out, key_out, state_out} !== {1'b1, 2'd2, 8'hA2, 2'd2})
                    $display("FAIL hold_event%0d got quiet=%b v=%b e=%0d k=%h s=%0d want 1 1 2 a2 2",
                             r, quiet, event_valid_out, event_out, key_out, state_out);
                else n_pass++;
            end
        end
        k = 0;
        for (int i = 1; i <= T + 100; i++) begin
            tick();
            if (event_valid_out) begin
                k = i;
                break;
            end
        end
        n_total++;
        if (k !== T || event_out !== 2'd3 || key_out !== 8'hA2)
            $display("FAIL hold_release got dt=%0d e=%0d k=%h want %0d 3 a2", k, event_out, key_out, T);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        send(32'h00FF_A25D);
        tick();
        repeat (10) tick();
        send(32'h00FF_18E7);
        tick();
        n_total++;
        if ({event_valid_out, event_out, key_out} !== {1'b1, 2'd3, 8'hA2})
            $display("FAIL b2b_release got v=%b e=%0d k=%h want 1 3 a2", event_valid_out, event_out, key_out);
        else n_pass++;
        tick();
        n_total++;
        if ({event_valid_out, event_out, key_out, state_out} !== {1'b1, 2'd1, 8'h18, 2'd1})
            $display("FAIL b2b_press got v=%b e=%0d k=%h s=%0d want 1 1 18 1",
                     event_valid_out, event_out, key_out, state_out);
        else n_pass++;
    endtask

    task automatic test_filter();
        do_reset();
        send(32'h19E6_A25D);
        tick();
        n_total++;
        if (f_valid !== 1'b0 || f_err !== 16'd0 || f_state !== 2'd0)
            $display("FAIL filter_drop got v=%b err=%0d s=%0d want 0 0 0", f_valid, f_err, f_state);
        else n_pass++;
        n_total++;
        if ({event_valid_out, event_out, addr_out, key_out} !== {1'b1, 2'd1, 8'h19, 8'hA2})
            $display("FAIL nofilter_press got v=%b e=%0d a=%h k=%h want 1 1 19 a2",
                     event_valid_out, event_out, addr_out, key_out);
        else n_pass++;
        repeat (5) tick();
        send(32'h00FF_A25D);
        tick();
        n_total++;
        if ({f_valid, f_event, f_key, f_addr} !== {1'b1, 2'd1, 8'hA2, 8'h00})
            $display("FAIL filter_pass got v=%b e=%0d k=%h a=%h want 1 1 a2 00", f_valid, f_event, f_key, f_addr);
        else n_pass++;
    endtask

    task automatic test_reset_held();
        bit quiet;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send(32'h00FF_A25D);
            tick();
        end
        n_total++;
        if (state_out !== 2'd2)
            $display("FAIL reach_held got s=%0d want 2", state_out);
        else n_pass++;
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        n_total++;
        if ({key_out, addr_out, event_out, event_valid_out, state_out, err_count_out} !== 37'd0)
            $display("FAIL midreset got k=%h a=%h e=%0d v=%b s=%0d err=%0d want all 0",
                     key_out, addr_out, event_out, event_valid_out, state_out, err_count_out);
        else n_pass++;
        quiet = 1'b1;
        for (int i = 0; i < T + 100; i++) begin
            tick();
            if (event_valid_out) quiet = 1'b0;
        end
        n_total++;
        if (!quiet)
            $display("FAIL no_release_after_reset got event want none");
        else n_pass++;
    endtask

    task automatic test_random();
        logic [32:0] sched[$];
        logic [7:0]  cmds[3];
        logic [7:0]  cmd, ncmd;
        int gap, e, reps, dl, merr, pend_edge;
        bit act, held, pendp, qs, fv, xv;
        logic [31:0] qc;
        logic [15:0] mk, pk, xk;
        logic [1:0]  xev, xst;
        cmds[0] = 8'hA2;
        cmds[1] = 8'h18;
        cmds[2] = 8'h45;
        for (int f = 0; f < 30; f++) begin
            case ($urandom_range(0, 3))
                0: gap = $urandom_range(3, 10);
                1: gap = $urandom_range(990, 1010);
                2: gap = $urandom_range(200, 600);
                default: gap = $urandom_range(1100, 1200);
            endcase
            for (int g = 0; g < gap; g++) sched.push_back(33'h0);
            cmd = cmds[$urandom_range(0, 2)];
            ncmd = ~cmd;
            if ($urandom_range(0, 4) == 0) ncmd = ncmd ^ 8'h01;
            sched.push_back({1'b1, 8'h00, 8'hFF, cmd, ncmd});
        end
        for (int g = 0; g < T + 50; g++) sched.push_back(33'h0);

        do_reset();
        e = 0; act = 0; held = 0; pendp = 0; reps = 0; dl = 0; merr = 0;
        qs = 0; qc = 0; mk = 0; pk = 0; pend_edge = 0;
        foreach (sched[i]) begin
            code_in = sched[i][31:0];
            new_code_in = sched[i][32];
            tick();
            new_code_in = 1'b0;
            e++;
            xv = 0; xev = 0; xk = mk;
            fv = qs && ((qc[31:24] ^ qc[23:16]) == 8'hFF) && ((qc[15:8] ^ qc[7:0]) == 8'hFF);
            if (qs && !fv) merr++;
            if (pendp) begin
                xv = 1; xev = 2'd1; mk = pk; xk = pk;
                act = 1; held = 0; reps = 0; dl = e + T; pendp = 0;
                if (fv) merr++;
            end else if (fv) begin
                if (!act) begin
                    mk = {qc[31:24], qc[15:8]};
                    xv = 1; xev = 2'd1; xk = mk;
                    act = 1; held = 0; reps = 0; dl = e + T;
                end else if ({qc[31:24], qc[15:8]} == mk) begin
                    dl = e + T;
                    if (held) begin
                        xv = 1; xev = 2'd2;
                    end else begin
                        reps = (reps + 1 > HR) ? HR : reps + 1;
                        if (reps == HR) begin
                            xv = 1; xev = 2'd2; held = 1;
                        end
                    end
                end else begin
                    xv = 1; xev = 2'd3;
                    pendp = 1; pk = {qc[31:24], qc[15:8]};
                end
            end else if (act && e == dl) begin
                xv = 1; xev = 2'd3; act = 0; held = 0;
            end
            qs = sched[i][32];
            qc = sched[i][31:0];
            xst = !act ? 2'd0 : (held ? 2'd2 : 2'd1);

            n_total++;
            if (event_valid_out !== xv || state_out !== xst || err_count_out !== merr[15:0])
                $display("FAIL rand_ctrl@%0d got v=%b s=%0d err=%0d want %b %0d %0d",
                         e, event_valid_out, state_out, err_count_out, xv, xst, merr);
            else n_pass++;
            if (xv) begin
                n_total++;
                if ({event_out, addr_out, key_out} !== {xev, xk})
                    $display("FAIL rand_event@%0d got e=%0d a=%h k=%h want %0d %h %h",
                             e, event_out, addr_out, key_out, xev, xk[15:8], xk[7:0]);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_errors();
        test_hold();
        test_back_to_back();
        test_filter();
        test_reset_held();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ir_key_controller.md
# ir_key_controller

Sequences the output of `ir_decoder` into debounced key events for the rest of the design. It consumes each decoded 32-bit NEC frame and checks the address/command complement bytes. An optional remote-address filter is applied. The block tracks the press/hold/release life cycle of one key, using a release timeout and a repeat counter. It sits directly downstream of `ir_decoder` and upstream of any UI/command logic.

## Interface
- `RELEASE_TIMEOUT`, default 12_000_000: cycles without a matching frame before a key is released (120 ms at 100 MHz).
- `HOLD_REPEATS`, default 3: matching repeat frames after PRESS before the first HOLD.
- `FILTER_EN`, default 0: 1 = accept only frames whose address equals `FILTER_ADDR`.
- `FILTER_ADDR`, default 8'h00: accepted remote address when filtering.
- `clk_in`, input, 1: system clock (100 MHz).
- `rst_in`, input, 1: reset. One clock; reset is synchronous and active-high.
- `code_in`, input, 32: frame from decoder `code_out`. Fields are [31:24] addr, [23:16] ~addr, [15:8] cmd, [7:0] ~cmd.
- `new_code_in`, input, 1: single-cycle strobe; `code_in` is valid in that cycle.
- `error_in`, input, 4: decoder `error_out`. A nonzero value means a frame was aborted.
- `key_out`, output, 8: command byte associated with the current event.
- `addr_out`, output, 8: address byte associated with the current event.
- `event_out`, output, 2: event code (`ir_event_t`).
- `event_valid_out`, output, 1: single-cycle strobe qualifying `key_out`, `addr_out` and `event_out`.
- `state_out`, output, 2: FSM state (`ir_key_state_t`), for debug.
- `err_count_out`, output, 16: count of checksum failures plus decoder errors. Saturates at 16'hFFFF.

## Operation
- Frame is **valid** when `addr^~addr == 8'hFF` and `cmd^~cmd == 8'hFF`, and the filter passes (filter passes whenever `FILTER_EN=0`).
- Checksum failure: `err_count_out` += 1. No other effect; the timer is not reloaded.
- Filtered frame: dropped silently. Not counted.
- Decoder errors: `err_count_out` += 1 on each cycle where `error_in` goes from zero to nonzero.
- **Same code**: valid frame whose {addr, cmd} equals the latched key.
- **IDLE**
  - Valid frame: latch the key, emit PRESS, load the timer, clear `rep_cnt`, go to PRESSED.
- **PRESSED**
  - Same code: reload the timer and increment `rep_cnt`.
    - When `rep_cnt` reaches `HOLD_REPEATS`, emit HOLD and go to HELD.
    - Otherwise emit nothing.
  - Different valid code: emit RELEASE for the old key, set `pend`, latch the new key.
  - Timer expiry: emit RELEASE and go to IDLE.
- **HELD**
  - Same code: reload the timer and emit HOLD.
  - Different valid code: handled as in PRESSED.
  - Timer expiry: emit RELEASE and go to IDLE.
- **Pending press**: in the cycle after `pend` is set, emit PRESS for the new key, load the timer, clear `rep_cnt`, go to PRESSED, clear `pend`.
- **Timer**: width `$clog2(RELEASE_TIMEOUT+1)`. Loaded with `RELEASE_TIMEOUT` and decremented every cycle in PRESSED/HELD. Expiry is the cycle in which it reads 1.
- `rep_cnt` saturates at `HOLD_REPEATS`.

## Timing
- Reset values: all outputs 0, `event_out=EV_NONE`, `state_out=ST_IDLE`. Internal timer, `rep_cnt` and `pend` are also cleared.
- Reset mid-operation clears everything on the next edge. No RELEASE is emitted.
- Latency: `new_code_in` at cycle N gives `event_valid_out` at N+1. A pending PRESS follows at N+2.
- RELEASE fires exactly `RELEASE_TIMEOUT` cycles after the cycle holding the last accepted PRESS/HOLD/repeat event.
- Same code coinciding with timer expiry: the frame wins. Treat it as a repeat; no RELEASE.
- Different valid code coinciding with timer expiry: one RELEASE (old key), then PRESS at N+2.
- `new_code_in` in the cycle a pending PRESS issues: the frame is dropped and `err_count_out` += 1.
- At most one `event_valid_out` per cycle. Outputs hold their values between strobes.

## Structure
- Package `ir_pkg` holds:
  - `ir_event_t`: EV_NONE=0, EV_PRESS=1, EV_HOLD=2, EV_RELEASE=3.
  - `ir_key_state_t`: ST_IDLE=0, ST_PRESSED=1, ST_HELD=2.
  - NEC field index constants.
- Sub-module `ir_frame_check`: registers the validity, checksum-fail and filter-pass flags plus the extracted addr/cmd. It contributes one pipeline stage, which is included in the N+1 latency above.
- Top-level `ir_key_controller` holds the FSM, timer, `rep_cnt`, error counter and output registers.

## Test plan
All scenarios use `RELEASE_TIMEOUT=1000`, `HOLD_REPEATS=2`.
1. One frame 32'h00FF_A25D at N → PRESS key 8'hA2, addr 8'h00 at N+1. RELEASE key 8'hA2 at N+1001. `state_out` returns to 0.
2. Frame 32'hABCD_1234 → no event, `err_count_out=1`. Then `error_in` 0→4→4→0 → `err_count_out=2`.
3. Frame 32'h00FF_A25D three times, 500 cycles apart → PRESS, then nothing, then HOLD. A fourth frame gives HOLD. RELEASE comes 1000 cycles after the last HOLD.
4. While 8'hA2 is pressed, frame 32'h00FF_18E7 at N → RELEASE 8'hA2 at N+1, PRESS 8'h18 at N+2.
5. `FILTER_EN=1`, `FILTER_ADDR=8'h00`, frame 32'h19E6_A25D → no event, `err_count_out` unchanged. Frame 32'h00FF_A25D → PRESS.
6. Reach HELD, assert `rst_in` for one cycle → all outputs 0 next cycle. No RELEASE is ever emitted for that key.
